dma_engine_param: RTL and testbench
===================================

Name: dma_engine_param

Overview:
- Parametrised next-generation DMA copy engine for the custom CPU SoC.
- Walks a ring of equal-size sub-buffers from tail_ptr up to head_ptr. Each sub-buffer is copied from src_base+offset to dest_base+offset in bursts of BURST_BEATS words through an internal FIFO.
- Auto-advances tail_ptr with ring wrap-around and raises an interrupt when the ring drains.
- Sits between the CPU register-write port and the memory read/write request/data channels.

Parameters:
- DATA_WIDTH, 32: data beat width in bits; power of 2, ≥32.
- BURST_BEATS, 8: beats per burst; power of 2, ≤256.
- FIFO_DEPTH, 16: internal FIFO entries; must be ≥ BURST_BEATS.
- RING_BYTES, 4096: ring size in bytes; offsets wrap modulo this; power of 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reg_wr_data  in  32  CPU write data
- reg_wr_en  in  6  one-hot write strobes: [0] src_base, [1] dest_base, [2] tail_ptr, [3] head_ptr, [4] dma_size, [5] ctrl_stat
- src_base, dest_base, tail_ptr, head_ptr, dma_size, ctrl_stat  out  32 each  register readback
- intr  out  1  equals ctrl_stat[31]
- rd_req_addr  out  32;  rd_req_len  out  8 (beats-1);  rd_req_valid  out  1;  rd_req_ready  in  1
- rd_rdata  in  DATA_WIDTH;  rd_valid  in  1;  rd_last  in  1;  rd_ready  out  1
- wr_req_addr  out  32;  wr_req_len  out  8;  wr_req_valid  out  1;  wr_req_ready  in  1
- wr_data  out  DATA_WIDTH;  wr_valid  out  1;  wr_last  out  1;  wr_ready  in  1

Behaviour:
- Reset: all registers 0, state IDLE, FIFO empty, all valid/ready outputs 0, rd_req_len = wr_req_len = BURST_BEATS-1 constant.
- Derived quantities:
  - BURST_BYTES = BURST_BEATS*DATA_WIDTH/8.
  - nbursts = dma_size / BURST_BYTES; low bits of dma_size are ignored.
- ctrl_stat bits: [0] EN, [1] BUSY (read-only), [2] LASTERR (sticky), [31] INTR.
  - CPU write to ctrl_stat loads bits 0, 2 and 31 and leaves BUSY engine-owned.
  - When the engine sets INTR in the same cycle as a CPU write, INTR = 1: engine set wins.
- FSM IDLE→RD_REQ→RD_DATA→WR_REQ→WR_DATA→(RD_REQ | ADVANCE)→(RD_REQ | IDLE):
  - IDLE→RD_REQ when EN, head_ptr≠tail_ptr, !INTR and nbursts≠0. On this transition, latch off = tail_ptr and clear the burst counter.
  - RD_REQ: rd_req_valid=1, rd_req_addr=src_base+off+burst*BURST_BYTES. Move on rd_req_valid&&rd_req_ready.
  - RD_DATA: rd_ready = FIFO not full. Each rd_valid&&rd_ready pushes rd_rdata and increments the beat counter. The burst ends when the counter reaches BURST_BEATS-1.
    - rd_last is checked against that beat; any mismatch sets LASTERR.
    - The beat count is authoritative.
  - WR_REQ: same address computed with dest_base. Leave on the wr_req handshake.
  - WR_DATA: wr_valid = FIFO not empty, wr_data = FIFO head (show-ahead), wr_last on beat BURST_BEATS-1. Pop on wr_valid&&wr_ready.
    - After the last beat: increment burst. If burst==nbursts go to ADVANCE, else RD_REQ.
  - ADVANCE (1 cycle): tail_ptr ← (tail_ptr+dma_size) mod RING_BYTES.
    - If the new tail equals head_ptr, set INTR and go to IDLE.
    - Else go to RD_REQ with off = new tail and burst = 0, without returning to IDLE.
- BUSY = state≠IDLE.
- CPU writes to src_base, dest_base, dma_size and tail_ptr are ignored while BUSY. head_ptr is always writable and is sampled fresh in ADVANCE.
- EN cleared mid-operation: the current burst completes through WR_DATA, then the engine goes to IDLE with tail_ptr not advanced. The sub-buffer restarts from burst 0 on re-enable.
- Address arithmetic is 32-bit modular. The FIFO never overflows because rd_ready is gated by full.
- Reset mid-operation returns to reset state immediately; in-flight transactions are abandoned (interconnect is co-reset).

Decomposition:
- Shared package dma_pkg:
  - state encoding constants (one-hot);
  - ctrl_stat bit indices (EN=0, BUSY=1, LASTERR=2, INTR=31);
  - reg_wr_en index constants.
- One sub-module dma_sync_fifo (WIDTH, DEPTH): show-ahead synchronous FIFO with push, pop, full, empty.

Test Plan:
- Basic copy: dma_size=64, tail=0, head=64, EN=1, DATA_WIDTH=32, BURST_BEATS=8 → 2 read bursts and 2 write bursts. Write addresses dest_base+0 and +32; data matches source; tail_ptr=64; intr=1; BUSY=0.
- Multi-buffer ring wrap: RING_BYTES=256, dma_size=64, tail=192, head=64 → sub-buffers at offsets 192 and 0 are processed back-to-back; tail_ptr=64; single intr.
- Backpressure: random rd_valid/wr_ready/req_ready stalls, FIFO_DEPTH=8 → no lost or duplicated beat; wr_last asserted exactly on beat 7 of each burst.
- rd_last error: rd_last asserted on beat 5 → LASTERR=1; the burst still takes 8 beats; the copy completes.
- Edge guards: dma_size=16 (<32), or head==tail, or INTR=1 → no rd_req_valid, engine stays IDLE. A CPU write to ctrl_stat with bit31=0 clears intr.
- Mid-operation control: clear EN during burst 0 of 2 → the burst completes, IDLE, tail unchanged. Separately, assert rst during RD_DATA → all outputs return to 0 the next cycle.

Source files
------------

// File: rtl/dma_engine_param_pkg.sv
// Shared definitions for the parametrised DMA copy engine: FSM state encoding,
// ctrl_stat bit positions, register strobe indices and an address helper.
package dma_pkg;

    localparam logic [5:0] ST_IDLE    = 6'b000001;
    localparam logic [5:0] ST_RD_REQ  = 6'b000010;
    localparam logic [5:0] ST_RD_DATA = 6'b000100;
    localparam logic [5:0] ST_WR_REQ  = 6'b001000;
    localparam logic [5:0] ST_WR_DATA = 6'b010000;
    localparam logic [5:0] ST_ADVANCE = 6'b100000;

    typedef enum logic [5:0] {
        IDLE    = ST_IDLE,
        RD_REQ  = ST_RD_REQ,
        RD_DATA = ST_RD_DATA,
        WR_REQ  = ST_WR_REQ,
        WR_DATA = ST_WR_DATA,
        ADVANCE = ST_ADVANCE
    } dma_state_e;

    localparam int CS_EN      = 0;
    localparam int CS_BUSY    = 1;
    localparam int CS_LASTERR = 2;
    localparam int CS_INTR    = 31;

    localparam int REG_SRC  = 0;
    localparam int REG_DEST = 1;
    localparam int REG_TAIL = 2;
    localparam int REG_HEAD = 3;
    localparam int REG_SIZE = 4;
    localparam int REG_CTRL = 5;
    localparam int NUM_REGS = 6;

    // Burst start address; everything wraps modulo 2^32.
    function automatic logic [31:0] burst_addr(input logic [31:0] base,
                                               input logic [31:0] off,
                                               input logic [31:0] burst,
                                               input int          shift);
        return base + off + (burst << shift);
    endfunction

endpackage

// File: rtl/dma_engine_param_if.sv
// Register port plus memory read/write request and data channels of the DMA
// engine; master is the engine side, slave the CPU/interconnect side.
interface dma_engine_param_if
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH = 32
);
    logic [31:0]           reg_wr_data;
    logic [NUM_REGS-1:0]   reg_wr_en;
    logic [31:0]           src_base;
    logic [31:0]           dest_base;
    logic [31:0]           tail_ptr;
    logic [31:0]           head_ptr;
    logic [31:0]           dma_size;
    logic [31:0]           ctrl_stat;
    logic                  intr;

    logic [31:0]           rd_req_addr;
    logic [7:0]            rd_req_len;
    logic                  rd_req_valid;
    logic                  rd_req_ready;
    logic [DATA_WIDTH-1:0] rd_rdata;
    logic                  rd_valid;
    logic                  rd_last;
    logic                  rd_ready;

    logic [31:0]           wr_req_addr;
    logic [7:0]            wr_req_len;
    logic                  wr_req_valid;
    logic                  wr_req_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_valid;
    logic                  wr_last;
    logic                  wr_ready;

    modport master (
        input  reg_wr_data, reg_wr_en,
        output src_base, dest_base, tail_ptr, head_ptr, dma_size, ctrl_stat, intr,
        output rd_req_addr, rd_req_len, rd_req_valid,
        input  rd_req_ready,
        input  rd_rdata, rd_valid, rd_last,
        output rd_ready,
        output wr_req_addr, wr_req_len, wr_req_valid,
        input  wr_req_ready,
        output wr_data, wr_valid, wr_last,
        input  wr_ready
    );

    modport slave (
        output reg_wr_data, reg_wr_en,
        input  src_base, dest_base, tail_ptr, head_ptr, dma_size, ctrl_stat, intr,
        input  rd_req_addr, rd_req_len, rd_req_valid,
        output rd_req_ready,
        output rd_rdata, rd_valid, rd_last,
        input  rd_ready,
        input  wr_req_addr, wr_req_len, wr_req_valid,
        output wr_req_ready,
        input  wr_data, wr_valid, wr_last,
        output wr_ready
    );

endinterface

// File: rtl/dma_engine_param_fifo.sv
// Show-ahead synchronous FIFO: head always presents the oldest entry, so a pop
// consumes the word already visible on head.
module dma_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rptr_q];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) wptr_d = (wptr_q == LAST_IDX) ? '0 : wptr_q + PTR_W'(1);
        if (do_pop)  rptr_d = (rptr_q == LAST_IDX) ? '0 : rptr_q + PTR_W'(1);
        if (do_push && !do_pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!do_push && do_pop) cnt_d = cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage is never reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= push_data;
    end

endmodule

// File: rtl/dma_engine_param.sv
// Ring-walking DMA copy engine: copies each sub-buffer from tail_ptr towards
// head_ptr in fixed-length bursts staged through a FIFO, then advances tail.
module dma_engine_param
    import dma_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int BURST_BEATS = 8,
    parameter int FIFO_DEPTH  = 16,
    parameter int RING_BYTES  = 4096
) (
    input  logic               clk,
    input  logic               rst,
    dma_engine_param_if.master bus
);
    localparam int BURST_BYTES = BURST_BEATS * DATA_WIDTH / 8;
    localparam int BB_SHIFT    = $clog2(BURST_BYTES);
    localparam int BEAT_W      = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_BEATS - 1);
    localparam logic [7:0]        REQ_LEN   = 8'(BURST_BEATS - 1);
    localparam logic [31:0]       RING_MASK = 32'(RING_BYTES - 1);

    dma_state_e        state_q, state_d;
    logic [31:0]       src_q, src_d, dest_q, dest_d, tail_q, tail_d;
    logic [31:0]       head_q, head_d, size_q, size_d;
    logic              en_q, en_d, lasterr_q, lasterr_d, intr_q, intr_d;
    logic [31:0]       off_q, off_d, burst_q, burst_d;
    logic [BEAT_W-1:0] rbeat_q, rbeat_d, wbeat_q, wbeat_d;

    logic [31:0]       nbursts, new_tail;
    logic              busy;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_head;

    logic [31:0]       rd_req_addr, wr_req_addr;
    logic              rd_req_valid, wr_req_valid, rd_ready, wr_valid, wr_last;

    assign nbursts  = size_q >> BB_SHIFT;
    assign new_tail = (tail_q + size_q) & RING_MASK;
    assign busy     = (state_q != IDLE);

    dma_sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (bus.rd_rdata),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dest_d       = dest_q;
        tail_d       = tail_q;
        head_d       = head_q;
        size_d       = size_q;
        en_d         = en_q;
        lasterr_d    = lasterr_q;
        intr_d       = intr_q;
        off_d        = off_q;
        burst_d      = burst_q;
        rbeat_d      = rbeat_q;
        wbeat_d      = wbeat_q;
        fifo_push    = 1'b0;
        fifo_pop     = 1'b0;
        rd_req_valid = 1'b0;
        rd_req_addr  = '0;
        rd_ready     = 1'b0;
        wr_req_valid = 1'b0;
        wr_req_addr  = '0;
        wr_valid     = 1'b0;
        wr_last      = 1'b0;

        if (bus.reg_wr_en[REG_HEAD]) head_d = bus.reg_wr_data;
        if (!busy) begin
            if (bus.reg_wr_en[REG_SRC])  src_d  = bus.reg_wr_data;
            if (bus.reg_wr_en[REG_DEST]) dest_d = bus.reg_wr_data;
            if (bus.reg_wr_en[REG_TAIL]) tail_d = bus.reg_wr_data;
            if (bus.reg_wr_en[REG_SIZE]) size_d = bus.reg_wr_data;
        end
        if (bus.reg_wr_en[REG_CTRL]) begin
            en_d      = bus.reg_wr_data[CS_EN];
            lasterr_d = bus.reg_wr_data[CS_LASTERR];
            intr_d    = bus.reg_wr_data[CS_INTR];
        end

        // Engine updates come after the CPU write so an engine set wins.
        case (state_q)
            IDLE: begin
                if (en_q && (head_q != tail_q) && !intr_q && (nbursts != '0)) begin
                    state_d = RD_REQ;
                    off_d   = tail_q;
                    burst_d = '0;
                end
            end
            RD_REQ: begin
                rd_req_valid = 1'b1;
                rd_req_addr  = burst_addr(src_q, off_q, burst_q, BB_SHIFT);
                if (bus.rd_req_ready) begin
                    state_d = RD_DATA;
                    rbeat_d = '0;
                end
            end
            RD_DATA: begin
                rd_ready = !fifo_full;
                if (bus.rd_valid && !fifo_full) begin
                    fifo_push = 1'b1;
                    if (bus.rd_last != (rbeat_q == LAST_BEAT)) lasterr_d = 1'b1;
                    if (rbeat_q == LAST_BEAT) state_d = WR_REQ;
                    else                      rbeat_d = rbeat_q + BEAT_W'(1);
                end
            end
            WR_REQ: begin
                wr_req_valid = 1'b1;
                wr_req_addr  = burst_addr(dest_q, off_q, burst_q, BB_SHIFT);
                if (bus.wr_req_ready) begin
                    state_d = WR_DATA;
                    wbeat_d = '0;
                end
            end
            WR_DATA: begin
                wr_valid = !fifo_empty;
                wr_last  = (wbeat_q == LAST_BEAT);
                if (!fifo_empty && bus.wr_ready) begin
                    fifo_pop = 1'b1;
                    if (wbeat_q == LAST_BEAT) begin
                        burst_d = burst_q + 32'd1;
                        // A cleared EN parks the engine without advancing tail.
                        if (!en_q)                            state_d = IDLE;
                        else if (burst_q + 32'd1 == nbursts) state_d = ADVANCE;
                        else                                  state_d = RD_REQ;
                    end else begin
                        wbeat_d = wbeat_q + BEAT_W'(1);
                    end
                end
            end
            ADVANCE: begin
                tail_d = new_tail;
                if (new_tail == head_q) begin
                    intr_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RD_REQ;
                    off_d   = new_tail;
                    burst_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            src_q     <= '0;
            dest_q    <= '0;
            tail_q    <= '0;
            head_q    <= '0;
            size_q    <= '0;
            en_q      <= 1'b0;
            lasterr_q <= 1'b0;
            intr_q    <= 1'b0;
            off_q     <= '0;
            burst_q   <= '0;
            rbeat_q   <= '0;
            wbeat_q   <= '0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dest_q    <= dest_d;
            tail_q    <= tail_d;
            head_q    <= head_d;
            size_q    <= size_d;
            en_q      <= en_d;
            lasterr_q <= lasterr_d;
            intr_q    <= intr_d;
            off_q     <= off_d;
            burst_q   <= burst_d;
            rbeat_q   <= rbeat_d;
            wbeat_q   <= wbeat_d;
        end
    end

    assign bus.src_base     = src_q;
    assign bus.dest_base    = dest_q;
    assign bus.tail_ptr     = tail_q;
    assign bus.head_ptr     = head_q;
    assign bus.dma_size     = size_q;
    assign bus.ctrl_stat    = {intr_q, 28'd0, lasterr_q, busy, en_q};
    assign bus.intr         = intr_q;
    assign bus.rd_req_addr  = rd_req_addr;
    assign bus.rd_req_len   = REQ_LEN;
    assign bus.rd_req_valid = rd_req_valid;
    assign bus.rd_ready     = rd_ready;
    assign bus.wr_req_addr  = wr_req_addr;
    assign bus.wr_req_len   = REQ_LEN;
    assign bus.wr_req_valid = wr_req_valid;
    assign bus.wr_data      = wr_valid ? fifo_head : '0;
    assign bus.wr_valid     = wr_valid;
    assign bus.wr_last      = wr_last;

endmodule

// File: tb/tb_dma_engine_param.sv
// Directed-sequence bench for dma_engine_param with randomised addresses and
// handshake stalls, checked against a ring-walk reference model.
module tb_dma_engine_param;
    import dma_pkg::*;

    localparam int DW          = 32;
    localparam int BB          = 8;
    localparam int FD          = 8;
    localparam int RB          = 256;
    localparam int BURST_BYTES = BB * DW / 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dma_engine_param_if #(.DATA_WIDTH(DW)) bus();

    dma_engine_param #(
        .DATA_WIDTH  (DW),
        .BURST_BEATS (BB),
        .FIFO_DEPTH  (FD),
        .RING_BYTES  (RB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    bit stall  = 1'b0;
    bit inject = 1'b0;

    logic [31:0] rd_addr_log[$];
    logic [31:0] wr_addr_log[$];
    logic [31:0] wdata_log[$];
    logic        wlast_log[$];
    logic [31:0] rd_pending[$];
    int          rbeat      = 0;
    int          rdv_cycles = 0;
    int          intr_rises = 0;
    logic        intr_prev  = 1'b0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ((a ^ 32'hA5C3_1E0F) * 32'h9E37_79B1) + 32'h1234_5677;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory read slave: accepts requests, returns beats of mem_word data.
    initial begin
        bus.rd_req_ready = 1'b0;
        bus.rd_valid     = 1'b0;
        bus.rd_rdata     = '0;
        bus.rd_last      = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                rd_pending.delete();
                rbeat            = 0;
                bus.rd_req_ready = 1'b0;
                bus.rd_valid     = 1'b0;
                bus.rd_last      = 1'b0;
                bus.rd_rdata     = '0;
            end else begin
                bus.rd_req_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
                if (rd_pending.size() > 0) begin
                    bus.rd_valid = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
                    bus.rd_rdata = mem_word(rd_pending[0] + 32'(4 * rbeat));
                    bus.rd_last  = (rbeat == BB - 1) || (inject && rbeat == 5);
                end else begin
                    bus.rd_valid = 1'b0;
                    bus.rd_last  = 1'b0;
                end
                #1;
                if (bus.rd_req_valid) rdv_cycles++;
                if (bus.rd_req_valid && bus.rd_req_ready) begin
                    rd_pending.push_back(bus.rd_req_addr);
                    rd_addr_log.push_back(bus.rd_req_addr);
                end
                if (bus.rd_valid && bus.rd_ready) begin
                    rbeat++;
                    if (rbeat == BB) begin
                        rbeat = 0;
                        void'(rd_pending.pop_front());
                    end
                end
            end
        end
    end

    // Memory write slave: records request addresses and data beats.
    initial begin
        bus.wr_req_ready = 1'b0;
        bus.wr_ready     = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.wr_req_ready = 1'b0;
                bus.wr_ready     = 1'b0;
            end else begin
                bus.wr_req_ready = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
                bus.wr_ready     = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            #1;
            if (!rst && bus.wr_req_valid && bus.wr_req_ready) wr_addr_log.push_back(bus.wr_req_addr);
            if (!rst && bus.wr_valid && bus.wr_ready) begin
                wdata_log.push_back(bus.wr_data);
                wlast_log.push_back(bus.wr_last);
            end
            if (bus.intr && !intr_prev) intr_rises++;
            intr_prev = bus.intr;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, observed %0d checks expected completion", checks);
        $fatal(1);
    end

    task automatic wr_reg(input int idx, input logic [31:0] v);
        bus.reg_wr_en   = NUM_REGS'(1 << idx);
        bus.reg_wr_data = v;
        @(negedge clk);
        bus.reg_wr_en   = '0;
    endtask

    task automatic clear_logs();
        rd_addr_log.delete();
        wr_addr_log.delete();
        wdata_log.delete();
        wlast_log.delete();
        intr_rises = 0;
        rdv_cycles = 0;
    endtask

    task automatic wait_idle(input string nm, input int budget);
        bit done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            #2;
            if (n > 2 && !bus.ctrl_stat[CS_BUSY]) begin
                done = 1'b1;
                break;
            end
        end
        check({nm, ":completion"}, 32'(done), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_first_read(input string nm);
        bit got = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #2;
            if (rd_addr_log.size() > 0) begin
                got = 1'b1;
                break;
            end
        end
        check({nm, ":first_read"}, 32'(got), 32'd1);
        @(negedge clk);
    endtask

    task automatic start_job(input logic [31:0] src, dest, size, tail, head);
        clear_logs();
        wr_reg(REG_SRC, src);
        wr_reg(REG_DEST, dest);
        wr_reg(REG_SIZE, size);
        wr_reg(REG_TAIL, tail);
        wr_reg(REG_HEAD, head);
        wr_reg(REG_CTRL, 32'h1);
    endtask

    // Reference: walk sub-buffers from tail in dma_size steps until head,
    // each split into bursts; limit >= 0 keeps only the first limit bursts.
    task automatic verify(input string nm, input logic [31:0] src, dest, size, tail, head,
                          input int limit);
        logic [31:0] offs[$];
        logic [31:0] exp_rd[$];
        logic [31:0] exp_wr[$];
        logic [31:0] exp_dat[$];
        logic [31:0] o;
        int nb;
        nb = int'(size) / BURST_BYTES;
        o  = tail;
        do begin
            offs.push_back(o);
            o = (o + size) % 32'(RB);
        end while (o != head && offs.size() < 16);
        foreach (offs[i]) begin
            for (int b = 0; b < nb; b++) begin
                exp_rd.push_back(src + offs[i] + 32'(b * BURST_BYTES));
                exp_wr.push_back(dest + offs[i] + 32'(b * BURST_BYTES));
            end
        end
        if (limit >= 0) begin
            while (exp_rd.size() > limit) begin
                void'(exp_rd.pop_back());
                void'(exp_wr.pop_back());
            end
        end
        foreach (exp_rd[j])
            for (int k = 0; k < BB; k++) exp_dat.push_back(mem_word(exp_rd[j] + 32'(4 * k)));

        check({nm, ":rd_bursts"}, 32'(rd_addr_log.size()), 32'(exp_rd.size()));
        foreach (exp_rd[j])
            if (j < rd_addr_log.size())
                check($sformatf("%s:rd_addr[%0d]", nm, j), rd_addr_log[j], exp_rd[j]);
        check({nm, ":wr_bursts"}, 32'(wr_addr_log.size()), 32'(exp_wr.size()));
        foreach (exp_wr[j])
            if (j < wr_addr_log.size())
                check($sformatf("%s:wr_addr[%0d]", nm, j), wr_addr_log[j], exp_wr[j]);
        check({nm, ":wr_beats"}, 32'(wdata_log.size()), 32'(exp_dat.size()));
        foreach (exp_dat[j]) begin
            if (j < wdata_log.size()) begin
                check($sformatf("%s:wr_data[%0d]", nm, j), wdata_log[j], exp_dat[j]);
                check($sformatf("%s:wr_last[%0d]", nm, j), 32'(wlast_log[j]), 32'((j % BB) == BB - 1));
            end
        end
    endtask

    task automatic post_job(input string nm, input logic [31:0] tail_exp, input bit lasterr_exp);
        check({nm, ":ctrl_stat"}, bus.ctrl_stat, 32'h8000_0001 | (32'(lasterr_exp) << CS_LASTERR));
        check({nm, ":tail_ptr"}, bus.tail_ptr, tail_exp);
        check({nm, ":intr"}, 32'(bus.intr), 32'd1);
        check({nm, ":intr_rises"}, 32'(intr_rises), 32'd1);
        wr_reg(REG_CTRL, 32'h0);
        check({nm, ":intr_cleared"}, 32'(bus.intr), 32'd0);
    endtask

    task automatic guard(input string nm, input logic [31:0] size, tail, head, ctrl);
        wr_reg(REG_SIZE, size);
        wr_reg(REG_TAIL, tail);
        wr_reg(REG_HEAD, head);
        rdv_cycles = 0;
        wr_reg(REG_CTRL, ctrl);
        repeat (20) @(negedge clk);
        check({nm, ":no_rd_req"}, 32'(rdv_cycles), 32'd0);
        check({nm, ":not_busy"}, 32'(bus.ctrl_stat[CS_BUSY]), 32'd0);
    endtask

    initial begin
        logic [31:0] src, dest;
        bus.reg_wr_en   = '0;
        bus.reg_wr_data = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst:ctrl_stat", bus.ctrl_stat, 32'h0);
        check("rst:tail_ptr", bus.tail_ptr, 32'h0);
        check("rst:src_base", bus.src_base, 32'h0);
        check("rst:rd_req_valid", 32'(bus.rd_req_valid), 32'd0);
        check("rst:wr_req_valid", 32'(bus.wr_req_valid), 32'd0);
        check("rst:rd_ready", 32'(bus.rd_ready), 32'd0);
        check("rst:wr_valid", 32'(bus.wr_valid), 32'd0);
        check("rst:rd_req_len", 32'(bus.rd_req_len), 32'(BB - 1));
        check("rst:wr_req_len", 32'(bus.wr_req_len), 32'(BB - 1));

        // Basic copy
        src  = $urandom;
        dest = $urandom;
        start_job(src, dest, 32'd64, 32'd0, 32'd64);
        wait_idle("basic", 2000);
        check("basic:src_base", bus.src_base, src);
        check("basic:dest_base", bus.dest_base, dest);
        check("basic:dma_size", bus.dma_size, 32'd64);
        verify("basic", src, dest, 32'd64, 32'd0, 32'd64, -1);
        post_job("basic", 32'd64, 1'b0);

        // Ring wrap across the end of the ring
        src  = $urandom;
        dest = $urandom;
        start_job(src, dest, 32'd64, 32'd192, 32'd64);
        wait_idle("wrap", 3000);
        verify("wrap", src, dest, 32'd64, 32'd192, 32'd64, -1);
        post_job("wrap", 32'd64, 1'b0);

        // Backpressure on every handshake
        stall = 1'b1;
        src   = $urandom;
        dest  = $urandom;
        start_job(src, dest, 32'd64, 32'd64, 32'd0);
        wait_idle("stall", 8000);
        verify("stall", src, dest, 32'd64, 32'd64, 32'd0, -1);
        post_job("stall", 32'd0, 1'b0);

        // Early rd_last: flagged but the copy still runs full bursts
        inject = 1'b1;
        src    = $urandom;
        dest   = $urandom;
        start_job(src, dest, 32'd64, 32'd0, 32'd64);
        wait_idle("lasterr", 8000);
        verify("lasterr", src, dest, 32'd64, 32'd0, 32'd64, -1);
        post_job("lasterr", 32'd64, 1'b1);
        check("lasterr:cleared", bus.ctrl_stat, 32'h0);
        inject = 1'b0;
        stall  = 1'b0;

        // Start guards
        guard("guard_small", 32'd16, 32'd0, 32'd64, 32'h1);
        wr_reg(REG_CTRL, 32'h0);
        guard("guard_empty", 32'd64, 32'd32, 32'd32, 32'h1);
        wr_reg(REG_CTRL, 32'h0);
        guard("guard_intr", 32'd64, 32'd0, 32'd64, 32'h8000_0001);
        check("guard_intr:intr", 32'(bus.intr), 32'd1);
        wr_reg(REG_CTRL, 32'h0);
        check("guard_intr:intr_cleared", 32'(bus.intr), 32'd0);

        // EN cleared during burst 0; register writes blocked while busy
        src  = $urandom;
        dest = $urandom;
        start_job(src, dest, 32'd64, 32'd0, 32'd64);
        wait_first_read("midop");
        wr_reg(REG_SRC, ~src);
        check("midop:src_locked", bus.src_base, src);
        wr_reg(REG_CTRL, 32'h0);
        wait_idle("midop", 2000);
        verify("midop", src, dest, 32'd64, 32'd0, 32'd64, 1);
        check("midop:tail_ptr", bus.tail_ptr, 32'd0);
        check("midop:intr", 32'(bus.intr), 32'd0);

        // Re-enable restarts the sub-buffer from burst 0
        start_job(src, dest, 32'd64, 32'd0, 32'd64);
        wait_idle("restart", 2000);
        verify("restart", src, dest, 32'd64, 32'd0, 32'd64, -1);
        post_job("restart", 32'd64, 1'b0);

        // Reset in the middle of a read burst
        start_job(src, dest, 32'd64, 32'd0, 32'd64);
        wait_first_read("rstmid");
        @(negedge clk);
        check("rstmid:rd_ready_before", 32'(bus.rd_ready), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rstmid:rd_req_valid", 32'(bus.rd_req_valid), 32'd0);
        check("rstmid:rd_ready", 32'(bus.rd_ready), 32'd0);
        check("rstmid:wr_req_valid", 32'(bus.wr_req_valid), 32'd0);
        check("rstmid:wr_valid", 32'(bus.wr_valid), 32'd0);
        check("rstmid:wr_data", bus.wr_data, 32'h0);
        check("rstmid:rd_req_addr", bus.rd_req_addr, 32'h0);
        check("rstmid:ctrl_stat", bus.ctrl_stat, 32'h0);
        check("rstmid:src_base", bus.src_base, 32'h0);
        check("rstmid:intr", 32'(bus.intr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
